cpu_out_uart: RTL and testbench
===============================

Name: cpu_out_uart

Overview:
- Output peripheral directly downstream of the cpu core.
- Consumes byte writes from the CPU output port and buffers them in a small FIFO.
- Serializes each byte as an 8N1 UART frame on a single tx line.
- Decouples CPU write timing from the slow serial rate, so bench runs can dump program output.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of 2, >= 2.
- CLKS_PER_BIT, 4, clk cycles per serial bit; >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- wr_en  in  1  CPU output-port write strobe, sampled on rising clk.
- wr_data  in  8  byte to transmit, valid when wr_en=1.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a write arrived while full; cleared only by reset.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - Pointers, count and FIFO state: count=0, empty=1, full=0, overflow=0.
  - FSM: IDLE, tx=1, tx_busy=0.
  - Reset mid-frame aborts the frame; tx returns high at once; buffered bytes are discarded.
- All outputs are registered or decoded from registers; no combinational path from wr_en or wr_data to any output.

- FIFO:
  - Circular buffer with rd_ptr, wr_ptr and count; pointers wrap modulo FIFO_DEPTH.
  - Push: wr_en=1 and full=0 at the edge stores wr_data at wr_ptr; wr_ptr+1, count+1.
  - Write while full (full=0 is false): data dropped, no pointer change, overflow set to 1.
  - full is evaluated from pre-edge count. A write when full is rejected even if a pop happens on the same edge.
  - Pop: performed by the FSM only, when in IDLE and empty=0. Head byte loads into the shift register; rd_ptr+1, count-1.
  - Push and pop on the same edge with 0 < count < FIFO_DEPTH: count unchanged, both pointers advance.
  - Push into an empty FIFO: the byte is not popped on the same edge. The pop occurs on the next edge at the earliest.

- FSM states and transitions:
  - IDLE: tx=1. If empty=0, pop the head byte and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - A single cycle counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.

- Timing:
  - The FSM transition, and the resulting tx change, are registered on the same edge as the pop.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Between back-to-back frames there is exactly 1 IDLE cycle with tx=1.
  - Latency from an accepted write into an empty, idle block to the tx falling edge: 2 clk edges.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with wr_en toggling -> tx=1, tx_busy=0, empty=1, full=0, count=0, overflow=0 throughout.
- Single byte (CLKS_PER_BIT=4): write 0xA5 once.
  - tx goes low 2 edges later for 4 cycles.
  - Data bits follow 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop bit high for 4 cycles; tx_busy=1 for 40 cycles; empty=1 afterwards.
- Fill and drain: write 0x01..0x04 on consecutive cycles.
  - count peaks at 3 (first byte already popped); full stays 0.
  - Four frames are sent in order, each separated by exactly 1 idle cycle.
- Overflow: while a frame is in progress, write 5 bytes consecutively (FIFO_DEPTH=4).
  - full=1 after the 4th write; the 5th byte is dropped and overflow=1.
  - Only the first 4 bytes are transmitted; overflow stays 1 until reset.
- Simultaneous push/pop: with count=2 and the FSM entering IDLE, assert wr_en on the pop edge -> count remains 2, byte order preserved.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> tx=1, tx_busy=0 and count=0 immediately (before the next clk edge); after release, no residual frame is sent.

Source files
------------

// File: rtl/cpu_out_uart.sv
// cpu_out_uart: byte sink for the CPU output port. Writes land in a small
// circular FIFO; an FSM drains it one byte at a time as 8N1 UART frames
// (start bit, 8 data bits LSB first, stop bit) on tx, CLKS_PER_BIT clocks
// per bit. Every output comes from a register or from a decode of registers.
module cpu_out_uart #(
  parameter int FIFO_DEPTH   = 4,  // power of 2, >= 2
  parameter int CLKS_PER_BIT = 4   // >= 2
) (
  input  logic                          clk,
  input  logic                          rst,      // async, active low
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          push, pop;

  // Status decodes come from the registered occupancy, so full/empty reflect
  // the pre-edge state: a write while full is dropped even if a pop lands on
  // the same edge, and a byte pushed into an empty FIFO waits one edge.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = (state == IDLE) & ~empty;
  assign tx_busy = (state != IDLE);

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Serializer state register; tx is registered so it changes on the same
  // edge as the state transition that selects it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cyc   <= '0;
      bidx  <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      bidx  <= bidx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  // Next-state and next-tx: one bit-period counter shared by all states,
  // cleared on every state or bit change.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bidx_n  = bidx;
    shift_n = shift;
    tx_n    = tx;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          state_n = START;
          shift_n = mem[rd_ptr];
          cyc_n   = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cyc == CYC_LAST) begin
          state_n = DATA;
          bidx_n  = '0;
          cyc_n   = '0;
          tx_n    = shift[0];
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      DATA: begin
        if (cyc == CYC_LAST) begin
          cyc_n = '0;
          if (bidx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bidx_n  = bidx + 1'b1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cyc == CYC_LAST) begin
          state_n = IDLE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cyc_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// Bench for cpu_out_uart. The reference is a transaction-level model: a byte
// queue for the FIFO, a "cycles left in current frame" countdown for the
// transmitter, and the expected tx level derived from the frame position.
module tb_cpu_out_uart;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx, tx_busy;
  logic [2:0] count;

  int errors = 0, checks = 0;
  string phase = "init";

  // reference model state
  byte unsigned mq[$];
  int           tx_left = 0;
  logic [7:0]   cur = 8'h00;
  bit           movf = 1'b0;
  int           pk = 0, fullseen = 0, busyc = 0;

  always #5 clk = ~clk;

  cpu_out_uart #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx(tx), .tx_busy(tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (tx_left == 0) return 1'b1;
    b = (FRAME - tx_left) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    tx_left = 0;
    movf    = 1'b0;
  endtask

  // One clock edge of the reference, using pre-edge occupancy for both the
  // pop decision and the full check.
  task automatic model_edge();
    bit pop_m, full_m;
    pop_m  = (tx_left == 0) && (mq.size() > 0);
    full_m = (mq.size() == DEPTH);
    if (wr_en && full_m) movf = 1'b1;
    if (tx_left > 0) tx_left--;
    if (pop_m) begin
      cur     = mq.pop_front();
      tx_left = FRAME;
    end
    if (wr_en && !full_m) mq.push_back(wr_data);
  endtask

  task automatic compare_all();
    chk({phase, ".tx"},       32'(tx),       32'(exp_tx()));
    chk({phase, ".tx_busy"},  32'(tx_busy),  32'(tx_left != 0));
    chk({phase, ".count"},    32'(count),    32'(mq.size()));
    chk({phase, ".empty"},    32'(empty),    32'(mq.size() == 0));
    chk({phase, ".full"},     32'(full),     32'(mq.size() == DEPTH));
    chk({phase, ".overflow"}, 32'(overflow), 32'(movf));
  endtask

  task automatic tick(input bit in_rst);
    if (!in_rst) model_edge();
    @(posedge clk);
    #1;
    compare_all();
    if (int'(count) > pk) pk = int'(count);
    if (full) fullseen++;
    if (tx_busy) busyc++;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1'b0);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    int n;

    // reset held with wr_en toggling
    phase = "reset";
    #2 rst = 1'b0;
    model_reset();
    #1 compare_all();
    for (int i = 0; i < 3; i++) begin
      wr_en   = ~wr_en;
      wr_data = 8'($urandom);
      tick(1'b1);
    end
    wr_en = 1'b0;
    rst   = 1'b1;
    idle(2);

    // single byte 0xA5
    phase = "single";
    wr(8'hA5);
    busyc = 0;
    idle(45);
    chk("single.busy_len", 32'(busyc), 32'd40);
    chk("single.empty_after", 32'(empty), 32'd1);

    // fill and drain
    phase = "fill";
    pk = 0; fullseen = 0;
    for (int i = 1; i <= 4; i++) wr(8'(i));
    idle(175);
    chk("fill.count_peak", 32'(pk), 32'd3);
    chk("fill.full_seen", 32'(fullseen), 32'd0);

    // overflow while a frame is in progress
    phase = "ovf";
    wr(8'($urandom));
    idle(2);
    for (int i = 0; i < 5; i++) begin
      wr(8'($urandom));
      if (i == 3) chk("ovf.full_at_4", 32'(full), 32'd1);
    end
    chk("ovf.set", 32'(overflow), 32'd1);
    idle(220);
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // push and pop on the same edge with two bytes queued
    phase = "pushpop";
    wr(8'($urandom));
    wr(8'($urandom));
    wr(8'($urandom));
    n = 0;
    while (tx_left != 0 && n < 100) begin
      tick(1'b0);
      n++;
    end
    chk("pushpop.wait_idle", 32'(tx_left), 32'd0);
    chk("pushpop.pre_count", 32'(count), 32'd2);
    wr(8'($urandom));
    chk("pushpop.count", 32'(count), 32'd2);
    idle(150);

    // reset during data bit 3
    phase = "midrst";
    wr(8'($urandom));
    wr(8'($urandom));
    wr(8'($urandom));
    n = 0;
    while (tx_left != FRAME - (4 * CPB + 2) && n < 100) begin
      tick(1'b0);
      n++;
    end
    chk("midrst.reach_bit3", 32'(tx_left), 32'(FRAME - (4 * CPB + 2)));
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midrst.tx_now", 32'(tx), 32'd1);
    chk("midrst.busy_now", 32'(tx_busy), 32'd0);
    chk("midrst.count_now", 32'(count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      wr_en   = ~wr_en;
      wr_data = 8'($urandom);
      tick(1'b1);
    end
    wr_en = 1'b0;
    rst   = 1'b1;
    busyc = 0;
    idle(50);
    chk("midrst.no_residual", 32'(busyc), 32'd0);

    // random writes against the model
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      tick(1'b0);
    end
    wr_en = 1'b0;
    idle(250);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
